// File: rtl/gcd_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module   : gcd_operand_feeder
// Brief    : Upstream stage for the RealGCD core. Buffers (a,b) operand pairs
//            in a small FIFO and issues them one at a time on the core's
//            io_in_* handshake, keeping at most one job outstanding. A job is
//            retired when the core raises io_out_valid.
// Config   : GCD_FEEDER_SWAP_EN - when defined, the issued pair is ordered so
//            the core always receives a >= b (unsigned). FIFO contents are
//            never modified either way.
// Revision : 1.0 - initial release
// ============================================================================
module gcd_operand_feeder #(
    parameter int WIDTH = 16,   // operand width, must match RealGCD
    parameter int DEPTH = 4,    // FIFO entries, power of 2, >= 2
    parameter int CNT_W = 16    // issued/completed counter width
) (
    input  logic                     clock,
    input  logic                     reset_n,
    // producer side
    input  logic                     io_enq_valid,
    output logic                     io_enq_ready,
    input  logic [WIDTH-1:0]         io_enq_bits_a,
    input  logic [WIDTH-1:0]         io_enq_bits_b,
    // RealGCD side
    output logic                     io_gcd_in_valid,
    input  logic                     io_gcd_in_ready,
    output logic [WIDTH-1:0]         io_gcd_in_bits_a,
    output logic [WIDTH-1:0]         io_gcd_in_bits_b,
    input  logic                     io_gcd_out_valid,
    // status
    output logic                     io_busy,
    output logic [$clog2(DEPTH):0]   io_count,
    output logic [CNT_W-1:0]         io_issued,
    output logic [CNT_W-1:0]         io_done_cnt
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    // DEPTH is a power of two, so "full" is just the MSB of the occupancy
    localparam logic [c_PTR_W:0]   c_FULL    = {1'b1, {c_PTR_W{1'b0}}};
    localparam logic [c_PTR_W:0]   c_CNT_INC = {{c_PTR_W{1'b0}}, 1'b1};
    localparam logic [c_PTR_W-1:0] c_PTR_INC = {{(c_PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   c_JOB_INC = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t               state_q;
    logic [c_PTR_W-1:0]   wr_ptr_q;
    logic [c_PTR_W-1:0]   rd_ptr_q;
    logic [c_PTR_W:0]     count_q;
    logic [c_PTR_W:0]     count_d;
    logic [CNT_W-1:0]     issued_q;
    logic [CNT_W-1:0]     done_q;
    logic                 valid_q;
    logic                 busy_q;

    logic [WIDTH-1:0]     mem_a_q [DEPTH];
    logic [WIDTH-1:0]     mem_b_q [DEPTH];

    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic [WIDTH-1:0]     w_head_a;
    logic [WIDTH-1:0]     w_head_b;

    // Ready reflects occupancy only; a same-cycle pop never frees the slot early.
    // Gated by reset so every output reads 0 while reset is held.
    assign w_full       = (count_q == c_FULL);
    assign io_enq_ready = reset_n & ~w_full;
    assign w_push       = io_enq_valid & io_enq_ready;
    // valid_q is high exactly while in ISSUE, so this is the issue handshake
    assign w_pop        = valid_q & io_gcd_in_ready;

    assign w_head_a     = mem_a_q[rd_ptr_q];
    assign w_head_b     = mem_b_q[rd_ptr_q];

    // Occupancy next-state: simultaneous push and pop leave it unchanged
    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_INC;
            2'b01:   count_d = count_q - c_CNT_INC;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage: data only, no reset needed since contents are unobservable
    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_a_q[wr_ptr_q] <= io_enq_bits_a;
            mem_b_q[wr_ptr_q] <= io_enq_bits_b;
        end
    end

    // Pointers, occupancy, job FSM with registered valid/busy, and job counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            issued_q <= '0;
            done_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + c_PTR_INC;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_INC;
            count_q <= count_d;

            case (state_q)
                ST_IDLE: begin
                    if (count_q != '0) begin
                        state_q <= ST_ISSUE;
                        valid_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (io_gcd_in_ready) begin
                        state_q  <= ST_WAIT;
                        valid_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        issued_q <= issued_q + c_JOB_INC;
                    end
                end
                ST_WAIT: begin
                    // completion always goes back through IDLE: one-cycle bubble
                    if (io_gcd_out_valid) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= done_q + c_JOB_INC;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Operands to the core: FIFO head while issuing, zero otherwise
    always_comb begin
        io_gcd_in_bits_a = '0;
        io_gcd_in_bits_b = '0;
        if (valid_q) begin
`ifdef GCD_FEEDER_SWAP_EN
            if (w_head_a < w_head_b) begin
                io_gcd_in_bits_a = w_head_b;
                io_gcd_in_bits_b = w_head_a;
            end else begin
                io_gcd_in_bits_a = w_head_a;
                io_gcd_in_bits_b = w_head_b;
            end
`else
            io_gcd_in_bits_a = w_head_a;
            io_gcd_in_bits_b = w_head_b;
`endif
        end
    end

    assign io_gcd_in_valid = valid_q;
    assign io_busy         = busy_q;
    assign io_count        = count_q;
    assign io_issued       = issued_q;
    assign io_done_cnt     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_gcd_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_operand_feeder
// Brief    : Directed self-checking bench for gcd_operand_feeder (WIDTH=16,
//            DEPTH=4, CNT_W=16). Honours GCD_FEEDER_SWAP_EN for expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_operand_feeder;

    logic        clk;
    logic        rst_n;
    logic        enq_valid;
    logic        enq_ready;
    logic [15:0] enq_a;
    logic [15:0] enq_b;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        busy;
    logic [2:0]  count;
    logic [15:0] issued;
    logic [15:0] done_cnt;

    int tests_run  = 0;
    int tests_fail = 0;

    gcd_operand_feeder #(
        .WIDTH (16),
        .DEPTH (4),
        .CNT_W (16)
    ) u_dut (
        .clock            (clk),
        .reset_n          (rst_n),
        .io_enq_valid     (enq_valid),
        .io_enq_ready     (enq_ready),
        .io_enq_bits_a    (enq_a),
        .io_enq_bits_b    (enq_b),
        .io_gcd_in_valid  (in_valid),
        .io_gcd_in_ready  (in_ready),
        .io_gcd_in_bits_a (in_a),
        .io_gcd_in_bits_b (in_b),
        .io_gcd_out_valid (out_valid),
        .io_busy          (busy),
        .io_count         (count),
        .io_issued        (issued),
        .io_done_cnt      (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // operands the core should see for a given FIFO head
    function automatic logic [15:0] exp_a(input logic [15:0] a, input logic [15:0] b);
`ifdef GCD_FEEDER_SWAP_EN
        return (a < b) ? b : a;
`else
        return a;
`endif
    endfunction

    function automatic logic [15:0] exp_b(input logic [15:0] a, input logic [15:0] b);
`ifdef GCD_FEEDER_SWAP_EN
        return (a < b) ? a : b;
`else
        return b;
`endif
    endfunction

    // retire the job in WAIT, observe the IDLE bubble, then take the next head
    task automatic retire_and_issue(input logic [15:0] a, input logic [15:0] b);
        out_valid = 1'b1;
        tick();
        out_valid = 1'b0;
        chk("bubble_busy", busy, 0);
        chk("bubble_valid", in_valid, 0);
        tick();
        chk("issue_valid", in_valid, 1);
        chk("issue_a", in_a, exp_a(a, b));
        chk("issue_b", in_b, exp_b(a, b));
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        chk("issue_busy", busy, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        enq_valid = 1'b0;
        enq_a     = '0;
        enq_b     = '0;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        // ---- 1. reset with clock running
        repeat (3) tick();
        chk("rst_enq_ready", enq_ready, 0);
        chk("rst_in_valid", in_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_issued", issued, 0);
        chk("rst_done", done_cnt, 0);
        chk("rst_bits", {in_a, in_b}, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_enq_ready", enq_ready, 1);

        // ---- 2. single job (48,32)
        enq_valid = 1'b1; enq_a = 16'd48; enq_b = 16'd32;
        tick();                                   // edge k
        enq_valid = 1'b0;
        chk("t2_count_k", count, 1);
        chk("t2_valid_k", in_valid, 0);
        tick();                                   // edge k+1 -> ISSUE
        chk("t2_valid_k1", in_valid, 1);
        chk("t2_a", in_a, 48);
        chk("t2_b", in_b, 32);
        in_ready = 1'b1;
        tick();                                   // edge k+2 -> WAIT
        in_ready = 1'b0;
        chk("t2_busy", busy, 1);
        chk("t2_issued", issued, 1);
        chk("t2_count_pop", count, 0);
        chk("t2_valid_off", in_valid, 0);
        chk("t2_bits_off", {in_a, in_b}, 0);
        repeat (4) tick();
        chk("t2_busy_hold", busy, 1);
        chk("t2_done_hold", done_cnt, 0);
        out_valid = 1'b1;
        tick();
        out_valid = 1'b0;
        chk("t2_busy_end", busy, 0);
        chk("t2_done", done_cnt, 1);

        // ---- 3. fill FIFO while the core is not ready
        enq_valid = 1'b1; enq_a = 16'd7;   enq_b = 16'd3;  tick();
        enq_a = 16'd100; enq_b = 16'd10; tick();
        enq_a = 16'd9;   enq_b = 16'd6;  tick();
        enq_a = 16'd5;   enq_b = 16'd5;  tick();
        chk("t3_count_full", count, 4);
        chk("t3_enq_ready", enq_ready, 0);
        chk("t3_head_valid", in_valid, 1);
        chk("t3_head_a", in_a, exp_a(16'd7, 16'd3));
        chk("t3_head_b", in_b, exp_b(16'd7, 16'd3));
        enq_a = 16'd1; enq_b = 16'd1;             // 5th push, must be refused
        tick();
        chk("t3_fifth_refused", count, 4);
        chk("t3_hold_a", in_a, exp_a(16'd7, 16'd3));

        // ---- 4. full FIFO: push attempt in the same cycle as the issue pop
        enq_a = 16'd11; enq_b = 16'd22;
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        chk("t4_count_4to3", count, 3);
        chk("t4_issued", issued, 2);
        chk("t4_ready_again", enq_ready, 1);
        tick();                                   // push now accepted
        enq_valid = 1'b0;
        chk("t4_count_refill", count, 4);

        // drain in order, one per completed job
        retire_and_issue(16'd100, 16'd10);
        retire_and_issue(16'd9,   16'd6);
        retire_and_issue(16'd5,   16'd5);
        retire_and_issue(16'd11,  16'd22);
        out_valid = 1'b1;
        tick();
        out_valid = 1'b0;
        chk("t3_issued_total", issued, 6);
        chk("t3_done_total", done_cnt, 6);
        chk("t3_count_empty", count, 0);

        // ---- 5. stray completion in IDLE, then async reset during WAIT
        out_valid = 1'b1;
        tick();
        out_valid = 1'b0;
        chk("t5_idle_pulse_done", done_cnt, 6);
        chk("t5_idle_busy", busy, 0);
        enq_valid = 1'b1; enq_a = 16'd40; enq_b = 16'd8;
        tick();
        enq_valid = 1'b0;
        tick();
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        chk("t5_wait_busy", busy, 1);
        chk("t5_issued", issued, 7);
        #2;
        rst_n = 1'b0;                             // between edges
        #1;
        chk("t5_async_busy", busy, 0);
        chk("t5_async_count", count, 0);
        chk("t5_async_issued", issued, 0);
        chk("t5_async_done", done_cnt, 0);
        chk("t5_async_valid", in_valid, 0);
        tick();
        rst_n = 1'b1;
        out_valid = 1'b1;                         // late completion of dropped job
        tick();
        out_valid = 1'b0;
        chk("t5_dropped_done", done_cnt, 0);
        chk("t5_dropped_busy", busy, 0);

        // ---- 6. operand ordering (3,12)
        enq_valid = 1'b1; enq_a = 16'd3; enq_b = 16'd12;
        tick();
        enq_valid = 1'b0;
        tick();
        chk("t6_valid", in_valid, 1);
`ifdef GCD_FEEDER_SWAP_EN
        chk("t6_a", in_a, 12);
        chk("t6_b", in_b, 3);
`else
        chk("t6_a", in_a, 3);
        chk("t6_b", in_b, 12);
`endif
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        out_valid = 1'b1;
        tick();
        out_valid = 1'b0;
        chk("t6_issued", issued, 1);
        chk("t6_done", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
`default_nettype wire
